wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the MIPS pipeline. Accepts retiring results from the MEM stage, waits for data-memory read data on loads, and aligns and extends it. Drives the single registered write port `wb_wreg_o` (type `reg_t`: `en`, `addr[4:0]`, `data[31:0]`) consumed by the register file, which writes it and bypasses it to same-cycle reads. Owns the load-completion handshake, so the pipeline stalls upstream while a load is outstanding.

## Interface
Parameters:
- `DATA_W`, 32, data width; fixed at 32 for this core.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high (`RST_ENABLE` = 1).
- `in_valid`  in  1  MEM stage presents a retiring instruction.
- `in_ready`  out  1  stage can accept; transfer occurs when `in_valid & in_ready`.
- `in_wreg`  in  `reg_t`  destination and ALU result; `data` ignored for loads.
- `in_is_load`  in  1  instruction is a load.
- `in_load_op`  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; 5–7 treated as LW.
- `in_byte_off`  in  2  low two bits of the load address.
- `dmem_rdata`  in  32  data-memory read word, aligned word, little-endian.
- `dmem_rvalid`  in  1  one-cycle pulse: `dmem_rdata` valid.
- `flush`  in  1  kill any in-flight or presented instruction.
- `wb_wreg_o`  out  `reg_t`  registered write to the register file.
- `align_err`  out  1  one-cycle pulse: misaligned load dropped.
- `busy`  out  1  high while state is not IDLE.

## Operation
- **States:** IDLE, WAIT_LOAD, DRAIN.
- **`in_ready`:** `in_ready = (state == IDLE)`, combinational from state only.
- **Transfers in IDLE:**
  - **Non-load:** next cycle `wb_wreg_o <= in_wreg`, with `en` forced 0 if `addr == 0`. Stay IDLE.
  - **Aligned load:** capture `addr`, `en`, op and offset. Go to WAIT_LOAD. `wb_wreg_o.en <= 0`.
  - **Alignment rules:** LH/LHU need `off[0] == 0`; LW needs `off == 0`; LB/LBU are always aligned.
  - **Misaligned load:** no register write. `align_err` pulses the next cycle. Stay IDLE.
- **No transfer:** `wb_wreg_o.en <= 0`, so each write is exactly a one-cycle pulse.
- **WAIT_LOAD:**
  - On `dmem_rvalid`, select the byte/half at the captured offset: byte at `rdata[8*off +: 8]`, half at `rdata[16*off[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register into `wb_wreg_o` next cycle with the captured `en`, forced 0 if `addr == 0`. Go to IDLE.
- **Flush:**
  - In IDLE, any same-cycle transfer is discarded: no write, no `align_err`.
  - In WAIT_LOAD without `dmem_rvalid`, go to DRAIN.
  - In WAIT_LOAD with `dmem_rvalid` in the same cycle, discard the data and go to IDLE.
  - In DRAIN, flush has no further effect.
- **DRAIN:** wait for `dmem_rvalid`, discard it, go to IDLE. No write.
- **Stray responses:** `dmem_rvalid` in IDLE is ignored.

## Timing
- **Reset (async, immediate):** state=IDLE; `wb_wreg_o` = all zeros (`en`=0, `addr`=0, `data`=0); `align_err`=0; `busy`=0; captured fields cleared. `in_ready`=1 during and after reset.
- **Reset mid-load:** abandons the load with no write. A later `dmem_rvalid` is ignored in IDLE.
- **Non-load latency:** 1 cycle from accept to `wb_wreg_o.en`.
- **Load latency:** 1 cycle after `dmem_rvalid`.
- **Back-to-back throughput:**
  - Non-loads: one per cycle.
  - Loads: next instruction accepted the cycle after `dmem_rvalid`, since `in_ready` rises when the state returns to IDLE.
- **Outputs:** all registered; no combinational path from inputs to `wb_wreg_o`, `align_err` or `busy`.

## Test plan
- **Reset, then non-load stream:** ADD to r3=0x1234 and SUB to r4=0xFFFF0000 on consecutive cycles. Expect `wb_wreg_o` `{1,3,0x1234}` then `{1,4,0xFFFF0000}` on consecutive cycles, then `en`=0.
- **Load extension:** `dmem_rdata`=0x80F17F02, `rvalid` 3 cycles after accept.
  - LB off=3 to r5 writes 0xFFFFFF80; LBU off=3 writes 0x00000080.
  - LH off=2 writes 0xFFFF80F1; LHU off=0 writes 0x00007F02; LW writes 0x80F17F02.
  - `in_ready`=0 until the cycle after `rvalid`.
- **Misalignment and r0:**
  - LW off=2 gives an `align_err` pulse and no write.
  - LH off=1 gives the same.
  - ADD to r0 with data 0x55 gives `wb_wreg_o.en`=0.
- **Flush during WAIT_LOAD:** flush 1 cycle after accepting LW r6, `rvalid` 2 cycles later. Expect no write, state passes through DRAIN, `in_ready` returns 1 the cycle after `rvalid`. The next ADD r7 writes normally.
- **Flush coincident with `rvalid`:** flush and `rvalid` in the same cycle. Expect no write and IDLE the next cycle.
- **Async reset in WAIT_LOAD:** assert `rst` mid-cycle. Expect `busy`=0 and `wb_wreg_o`=0 immediately. A subsequent stray `rvalid` produces no write.

Source files
------------

// File: rtl/wb_stage.sv
// Purpose: MIPS writeback stage; aligns and extends load data and drives the registered RF write port.
// Latency: 1 cycle from accept (non-load) or from dmem_rvalid (load) to wb_wreg_o.en.
// Backpressure: in_ready is low while a load is outstanding or being drained.
//
// Ports: clk/rst (async active-high); in_valid/in_ready handshake with in_wreg, in_is_load,
// in_load_op, in_byte_off from MEM; dmem_rdata/dmem_rvalid read response; flush kill;
// wb_wreg_o write port, align_err pulse, busy status.

package wb_stage_pkg;
  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_t;
endpackage

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_t              in_wreg,
  input  logic              in_is_load,
  input  logic [2:0]        in_load_op,
  input  logic [1:0]        in_byte_off,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  input  logic              flush,
  output reg_t              wb_wreg_o,
  output logic              align_err,
  output logic              busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LOAD = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;

  logic [1:0] state_q, state_d;
  reg_t       wreg_q, wreg_d;
  logic       align_err_q, align_err_d;
  logic       cap_en_q, cap_en_d;
  logic [4:0] cap_addr_q, cap_addr_d;
  logic [2:0] cap_op_q, cap_op_d;
  logic [1:0] cap_off_q, cap_off_d;

  logic        aligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wb_wreg_o = wreg_q;
  assign align_err = align_err_q;

  // Op codes 5..7 behave as LW, so they fall into the word rule.
  always_comb begin
    case (in_load_op)
      3'd0, 3'd1: aligned = 1'b1;
      3'd2, 3'd3: aligned = ~in_byte_off[0];
      default:    aligned = (in_byte_off == 2'd0);
    endcase
  end

  // Lane select and extension from the captured op/offset.
  always_comb begin
    case (cap_off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = cap_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_op_q)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {24'd0, ld_byte};
      3'd2:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd3:    ld_val = {16'd0, ld_half};
      default: ld_val = dmem_rdata[31:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wreg_d      = '0;      // writes are single-cycle pulses
    align_err_d = 1'b0;
    cap_en_d    = cap_en_q;
    cap_addr_d  = cap_addr_q;
    cap_op_d    = cap_op_q;
    cap_off_d   = cap_off_q;
    case (state_q)
      IDLE: begin
        // Stray dmem_rvalid is ignored here.
        if (in_valid && !flush) begin
          if (!in_is_load) begin
            wreg_d    = in_wreg;
            wreg_d.en = in_wreg.en && (in_wreg.addr != 5'd0);
          end else if (aligned) begin
            cap_en_d   = in_wreg.en;
            cap_addr_d = in_wreg.addr;
            cap_op_d   = in_load_op;
            cap_off_d  = in_byte_off;
            state_d    = WAIT_LOAD;
          end else begin
            align_err_d = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (!flush) begin
            wreg_d.en   = cap_en_q && (cap_addr_q != 5'd0);
            wreg_d.addr = cap_addr_q;
            wreg_d.data = ld_val;
          end
        end else if (flush) begin
          // The response is still coming; swallow it in DRAIN.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wreg_q      <= '0;
      align_err_q <= 1'b0;
      cap_en_q    <= 1'b0;
      cap_addr_q  <= 5'd0;
      cap_op_q    <= 3'd0;
      cap_off_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      wreg_q      <= wreg_d;
      align_err_q <= align_err_d;
      cap_en_q    <= cap_en_d;
      cap_addr_q  <= cap_addr_d;
      cap_op_q    <= cap_op_d;
      cap_off_q   <= cap_off_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  reg_t        in_wreg;
  logic        in_is_load;
  logic [2:0]  in_load_op;
  logic [1:0]  in_byte_off;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        flush;
  reg_t        wb_wreg_o;
  logic        align_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: an outstanding load record plus a drain flag.
  logic        m_pend, m_drain;
  logic        m_en;
  logic [4:0]  m_addr;
  int          m_op, m_off;
  reg_t        exp_wreg;
  logic        exp_err;

  wb_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg(in_wreg), .in_is_load(in_is_load), .in_load_op(in_load_op),
    .in_byte_off(in_byte_off), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .flush(flush), .wb_wreg_o(wb_wreg_o), .align_err(align_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_drain = 0; m_en = 0; m_addr = 0; m_op = 0; m_off = 0;
    exp_wreg = '0; exp_err = 0;
  endtask

  function automatic logic [31:0] extract(input int op, input int off, input logic [31:0] word);
    longint unsigned v;
    int size;
    size = (op <= 1) ? 1 : (op <= 3) ? 2 : 4;
    v = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
    if ((op == 0 || op == 2) && v >= (64'd1 << (8 * size - 1)))
      v = v + (64'hFFFF_FFFF_FFFF_FFFF << (8 * size));
    return v[31:0];
  endfunction

  task automatic model_step(input logic v, input reg_t w, input logic ld, input int op,
                            input int off, input logic [31:0] rd, input logic rv, input logic fl);
    int size;
    exp_wreg = '0;
    exp_err  = 0;
    if (!m_pend && !m_drain) begin
      if (v && !fl) begin
        size = (op <= 1) ? 1 : (op <= 3) ? 2 : 4;
        if (!ld) begin
          exp_wreg = w;
          if (w.addr == 0) exp_wreg.en = 0;
        end else if (off % size == 0) begin
          m_pend = 1; m_en = w.en; m_addr = w.addr; m_op = op; m_off = off;
        end else begin
          exp_err = 1;
        end
      end
    end else if (m_pend) begin
      if (rv) begin
        m_pend = 0;
        if (!fl) begin
          exp_wreg.en   = m_en && (m_addr != 0);
          exp_wreg.addr = m_addr;
          exp_wreg.data = extract(m_op, m_off, rd);
        end
      end else if (fl) begin
        m_pend = 0; m_drain = 1;
      end
    end else if (rv) begin
      m_drain = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and compare at the next falling edge.
  task automatic cyc(input logic v, input reg_t w, input logic ld, input logic [2:0] op,
                     input logic [1:0] off, input logic [31:0] rd, input logic rv, input logic fl);
    in_valid = v; in_wreg = w; in_is_load = ld; in_load_op = op; in_byte_off = off;
    dmem_rdata = rd; dmem_rvalid = rv; flush = fl;
    model_step(v, w, ld, int'(op), int'(off), rd, rv, fl);
    @(negedge clk);
    chk("wreg_en", {31'd0, wb_wreg_o.en}, {31'd0, exp_wreg.en});
    if (exp_wreg.en) begin
      chk("wreg_addr", {27'd0, wb_wreg_o.addr}, {27'd0, exp_wreg.addr});
      chk("wreg_data", wb_wreg_o.data, exp_wreg.data);
    end
    chk("align_err", {31'd0, align_err}, {31'd0, exp_err});
    chk("busy", {31'd0, busy}, {31'd0, m_pend | m_drain});
    chk("in_ready", {31'd0, in_ready}, {31'd0, ~(m_pend | m_drain)});
  endtask

  function automatic reg_t mk(input logic en, input logic [4:0] a, input logic [31:0] d);
    reg_t r;
    r.en = en; r.addr = a; r.data = d;
    return r;
  endfunction

  task automatic idle(input logic [31:0] rd, input logic rv, input logic fl);
    cyc(0, '0, 0, 3'd0, 2'd0, rd, rv, fl);
  endtask

  localparam logic [31:0] RD = 32'h80F1_7F02;

  task automatic do_load(input logic [2:0] op, input logic [1:0] off, input logic [4:0] a,
                         input logic [31:0] lit, input string name);
    cyc(1, mk(1, a, 32'hDEAD_BEEF), 1, op, off, RD, 0, 0);
    idle(RD, 0, 0);
    chk({name, "_ready_wait"}, {31'd0, in_ready}, 32'd0);
    idle(RD, 0, 0);
    idle(RD, 1, 0);
    chk({name, "_data"}, wb_wreg_o.data, lit);
    chk({name, "_en"}, {31'd0, wb_wreg_o.en}, 32'd1);
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_wreg = '0; in_is_load = 0; in_load_op = 0; in_byte_off = 0;
    dmem_rdata = 0; dmem_rvalid = 0; flush = 0;
    model_reset();
    @(negedge clk);
    chk("rst_wreg", wb_wreg_o[31:0], 32'd0);
    chk("rst_wreg_hi", {26'd0, wb_wreg_o[37:32]}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, align_err}, 32'd0);
    rst = 0;

    // Non-load stream.
    cyc(1, mk(1, 5'd3, 32'h1234), 0, 3'd0, 2'd0, 0, 0, 0);
    chk("add_r3", wb_wreg_o[37:0] == {1'b1, 5'd3, 32'h1234} ? 32'd1 : 32'd0, 32'd1);
    cyc(1, mk(1, 5'd4, 32'hFFFF_0000), 0, 3'd0, 2'd0, 0, 0, 0);
    chk("sub_r4", wb_wreg_o[37:0] == {1'b1, 5'd4, 32'hFFFF_0000} ? 32'd1 : 32'd0, 32'd1);
    idle(0, 0, 0);
    chk("stream_end_en", {31'd0, wb_wreg_o.en}, 32'd0);

    // Load extension.
    do_load(3'd0, 2'd3, 5'd5, 32'hFFFF_FF80, "lb");
    do_load(3'd1, 2'd3, 5'd5, 32'h0000_0080, "lbu");
    do_load(3'd2, 2'd2, 5'd5, 32'hFFFF_80F1, "lh");
    do_load(3'd3, 2'd0, 5'd5, 32'h0000_7F02, "lhu");
    do_load(3'd4, 2'd0, 5'd5, 32'h80F1_7F02, "lw");

    // Misalignment and r0.
    cyc(1, mk(1, 5'd9, 0), 1, 3'd4, 2'd2, RD, 0, 0);
    chk("lw_mis_err", {31'd0, align_err}, 32'd1);
    chk("lw_mis_en", {31'd0, wb_wreg_o.en}, 32'd0);
    cyc(1, mk(1, 5'd9, 0), 1, 3'd2, 2'd1, RD, 0, 0);
    chk("lh_mis_err", {31'd0, align_err}, 32'd1);
    cyc(1, mk(1, 5'd0, 32'h55), 0, 3'd0, 2'd0, 0, 0, 0);
    chk("r0_en", {31'd0, wb_wreg_o.en}, 32'd0);
    chk("r0_err", {31'd0, align_err}, 32'd0);

    // Flush during WAIT_LOAD, response arrives later.
    cyc(1, mk(1, 5'd6, 0), 1, 3'd4, 2'd0, RD, 0, 0);
    idle(RD, 0, 1);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    idle(RD, 0, 0);
    idle(RD, 1, 0);
    chk("drain_en", {31'd0, wb_wreg_o.en}, 32'd0);
    chk("drain_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, mk(1, 5'd7, 32'h77), 0, 3'd0, 2'd0, 0, 0, 0);
    chk("add_r7", wb_wreg_o[37:0] == {1'b1, 5'd7, 32'h77} ? 32'd1 : 32'd0, 32'd1);

    // Flush coincident with rvalid.
    cyc(1, mk(1, 5'd8, 0), 1, 3'd4, 2'd0, RD, 0, 0);
    idle(RD, 1, 1);
    chk("flush_rv_en", {31'd0, wb_wreg_o.en}, 32'd0);
    chk("flush_rv_busy", {31'd0, busy}, 32'd0);

    // Async reset mid-load.
    cyc(1, mk(1, 5'd9, 0), 1, 3'd4, 2'd0, RD, 0, 0);
    idle(RD, 0, 0);
    #2 rst = 1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wreg", wb_wreg_o[31:0], 32'd0);
    chk("arst_wreg_hi", {26'd0, wb_wreg_o[37:32]}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle(RD, 1, 0);
    chk("stray_en", {31'd0, wb_wreg_o.en}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 1) == 1,
          mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom),
          $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
